// File: rtl/alu_serial_sequencer.sv
// Bit-serial operand sequencer driving a single 1-bit full-adder cell, LSB first.
// Latency: start accepted at edge N -> busy for WIDTH cycles -> done pulse in cycle N+WIDTH+1.
// Backpressure: start is ignored while busy; accepted in IDLE or in the DONE cycle (back-to-back).
// Optional: define ALU_SERIAL_FLAGS_EN to add ovf/zero flag outputs.
module alu_serial_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [1:0]         op_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_bit;
  logic               fa_b, fa_sum, fa_cout;
  logic [WIDTH-1:0]   result_nxt;

  // Full-adder cell: si selects what the B input contributes (0, B, ~B, 1).
  always_comb begin
    fa_b = 1'b0;
    case (op_r)
      2'b00:   fa_b = 1'b0;
      2'b01:   fa_b = b_sh[0];
      2'b10:   fa_b = ~b_sh[0];
      default: fa_b = 1'b1;
    endcase
    fa_sum  = a_sh[0] ^ fa_b ^ carry_r;
    fa_cout = (a_sh[0] & fa_b) | (a_sh[0] & carry_r) | (fa_b & carry_r);
  end

  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));
  assign result_nxt = {fa_sum, result[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status outputs; start is only honoured outside SHIFT.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and bit-serial datapath; the sum enters at the MSB and moves down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      op_r    <= 2'b00;
      carry_r <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      op_r    <= op_sel;
      carry_r <= cin;
      cnt     <= '0;
      result  <= '0;
    end else if (state_q == SHIFT) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      carry_r <= fa_cout;
      cnt     <= cnt + CNT_W'(1);
      result  <= result_nxt;
      if (last_bit) cout <= fa_cout;
    end
  end

`ifdef ALU_SERIAL_FLAGS_EN
  // Flags are captured on the final bit so they become valid with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (state_q == SHIFT && last_bit && !accept) begin
      ovf  <= carry_r ^ fa_cout;
      zero <= (result_nxt == '0);
    end
  end
`endif

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer (WIDTH=8); inputs driven and outputs sampled on negedge.
module tb_alu_serial_sequencer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op_sel;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef ALU_SERIAL_FLAGS_EN
  logic             ovf;
  logic             zero;
`endif

  int checks = 0;
  int fails  = 0;

  alu_serial_sequencer #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sel (op_sel),
    .cin    (cin),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    .ovf    (ovf),
    .zero   (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse at a negedge; the following posedge samples it.
  task automatic launch(input logic [1:0] op, input logic [7:0] av, input logic [7:0] bv, input logic c);
    @(negedge clk);
    op_sel = op; a = av; b = bv; cin = c; start = 1'b1;
    @(posedge clk);
  endtask

  // Wait (bounded) for done; n = cycle index where done seen (1 = first cycle after accept).
  task automatic wait_done(output int n, output int busyc);
    n = 0; busyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) busyc++;
    end while (!done && n < 30);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op_sel = 2'b00; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, result, cout} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h cout=%b, required all 0", busy, done, result, cout);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_add;
    int n, bc;
    launch(2'b01, 8'h35, 8'h4A, 1'b0);
    wait_done(n, bc);
    checks++;
    if (n !== 9 || bc !== 8) begin
      fails++;
      $display("FAIL add_latency: done at cycle %0d busy cycles %0d, required 9 and 8", n, bc);
    end
    checks++;
    if (result !== 8'h7F || cout !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL add_result: result=%h cout=%b busy=%b, required 7f 0 0", result, cout, busy);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== 8'h7F) begin
      fails++;
      $display("FAIL add_hold: done=%b result=%h, required 0 7f", done, result);
    end
  endtask

  task automatic test_sub;
    int n, bc;
    launch(2'b10, 8'h10, 8'h01, 1'b1);
    wait_done(n, bc);
    checks++;
    if (n !== 9 || result !== 8'h0F || cout !== 1'b1) begin
      fails++;
      $display("FAIL sub: cycle %0d result=%h cout=%b, required 9 0f 1", n, result, cout);
    end
  endtask

  task automatic test_inc_dec;
    int n, bc;
    launch(2'b00, 8'hFF, 8'hA5, 1'b1);
    wait_done(n, bc);
    checks++;
    if (result !== 8'h00 || cout !== 1'b1) begin
      fails++;
      $display("FAIL inc: result=%h cout=%b, required 00 1", result, cout);
    end
    launch(2'b11, 8'h00, 8'h3C, 1'b0);
    wait_done(n, bc);
    checks++;
    if (result !== 8'hFF || cout !== 1'b0) begin
      fails++;
      $display("FAIL dec: result=%h cout=%b, required ff 0", result, cout);
    end
  endtask

  task automatic test_reset_mid;
    int n, bc;
    logic saw_done;
    // Leave cout=1 beforehand so the reset clearing it is observable.
    launch(2'b00, 8'hFF, 8'h00, 1'b1);
    wait_done(n, bc);
    launch(2'b01, 8'h12, 8'h34, 1'b0);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL midreset_busy_before: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, result, cout} !== 11'd0) begin
      fails++;
      $display("FAIL midreset_clear: busy=%b done=%b result=%h cout=%b, required all 0", busy, done, result, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      fails++;
      $display("FAIL midreset_no_done: activity=%b, required 0", saw_done);
    end
    launch(2'b01, 8'h22, 8'h33, 1'b0);
    wait_done(n, bc);
    checks++;
    if (n !== 9 || result !== 8'h55 || cout !== 1'b0) begin
      fails++;
      $display("FAIL midreset_fresh: cycle %0d result=%h cout=%b, required 9 55 0", n, result, cout);
    end
  endtask

  task automatic test_busy_ignore;
    int n, bc;
    launch(2'b01, 8'h35, 8'h4A, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    op_sel = 2'b11; a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 4; bc = 4;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end
    checks++;
    if (n !== 9 || bc !== 8 || result !== 8'h7F || cout !== 1'b0) begin
      fails++;
      $display("FAIL busy_ignore: cycle %0d busy %0d result=%h cout=%b, required 9 8 7f 0", n, bc, result, cout);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL busy_ignore_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int n, bc;
    launch(2'b01, 8'h01, 8'h02, 1'b0);
    wait_done(n, bc);
    // At the done cycle, request the next op immediately.
    op_sel = 2'b10; a = 8'h05; b = 8'h07; cin = 1'b1; start = 1'b1;
    checks++;
    if (done !== 1'b1 || result !== 8'h03) begin
      fails++;
      $display("FAIL b2b_first: done=%b result=%h, required 1 03", done, result);
    end
    wait_done(n, bc);
    checks++;
    if (n !== 9 || bc !== 8) begin
      fails++;
      $display("FAIL b2b_gap: done at cycle %0d busy %0d, required 9 8", n, bc);
    end
    // 5 - 7 = 0xFE, no carry out.
    checks++;
    if (result !== 8'hFE || cout !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: result=%h cout=%b, required fe 0", result, cout);
    end
  endtask

`ifdef ALU_SERIAL_FLAGS_EN
  task automatic test_flags;
    int n, bc;
    launch(2'b01, 8'h7F, 8'h01, 1'b0);
    wait_done(n, bc);
    checks++;
    if (result !== 8'h80 || ovf !== 1'b1 || zero !== 1'b0 || cout !== 1'b0) begin
      fails++;
      $display("FAIL flags_ovf: result=%h ovf=%b zero=%b cout=%b, required 80 1 0 0", result, ovf, zero, cout);
    end
    launch(2'b01, 8'hFF, 8'h01, 1'b0);
    wait_done(n, bc);
    checks++;
    if (result !== 8'h00 || ovf !== 1'b0 || zero !== 1'b1 || cout !== 1'b1) begin
      fails++;
      $display("FAIL flags_zero: result=%h ovf=%b zero=%b cout=%b, required 00 0 1 1", result, ovf, zero, cout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_inc_dec();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
`ifdef ALU_SERIAL_FLAGS_EN
    test_flags();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
